// File: rtl/persiana_planta.sv
// Plant emulator for the automatic blind: turns subir/bajar motor commands into a
// modelled blind position and drives the Ssup/Smed/Sinf limit sensors back.
module persiana_planta #(
  parameter int unsigned TRAVEL_TICKS = 4,   // edges per position step while running
  parameter int unsigned POS_W        = 4,
  parameter int unsigned POS_MAX      = 12,  // fully open
  parameter int unsigned MED_POS      = 6,   // half open
  parameter int unsigned RESET_POS    = 0    // 0 = fully closed
) (
  input  logic             Reloj,
  input  logic             reset,
  input  logic             subir,
  input  logic             bajar,
  output logic             Ssup,
  output logic             Smed,
  output logic             Sinf,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam int unsigned CntW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(TRAVEL_TICKS - 1);
  localparam logic [POS_W-1:0] PosMax  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PosMed  = POS_W'(MED_POS);
  localparam logic [POS_W-1:0] PosRst  = POS_W'(RESET_POS);

  typedef enum logic [1:0] {
    StReposo   = 2'd0,
    StSubiendo = 2'd1,
    StBajando  = 2'd2,
    StFalla    = 2'd3
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [POS_W-1:0] pos_q;
  logic             step_done;

  assign step_done = (cnt_q == CntLast);

  // Motor FSM plus travel model; leaving a motion state always drops partial tick progress.
  always_ff @(posedge Reloj or posedge reset) begin
    if (reset) begin
      state_q <= StReposo;
      cnt_q   <= '0;
      pos_q   <= PosRst;
    end else if (subir && bajar) begin
      // Contradictory commands win over everything; position is frozen.
      state_q <= StFalla;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StFalla: begin
          // Mandatory REPOSO cycle before any restart.
          state_q <= StReposo;
          cnt_q   <= '0;
        end
        StReposo: begin
          cnt_q <= '0;
          if (subir) begin
            state_q <= StSubiendo;
          end else if (bajar) begin
            state_q <= StBajando;
          end
        end
        StSubiendo: begin
          if (bajar || !subir) begin
            // Reversal or release: one dead-time cycle in REPOSO.
            state_q <= StReposo;
            cnt_q   <= '0;
          end else if (pos_q < PosMax) begin
            if (step_done) begin
              pos_q <= pos_q + 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        StBajando: begin
          if (subir || !bajar) begin
            state_q <= StReposo;
            cnt_q   <= '0;
          end else if (pos_q != '0) begin
            if (step_done) begin
              pos_q <= pos_q - 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q <= StReposo;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Sensors and status decode registered state/position only, never the commands.
  assign pos    = pos_q;
  assign Ssup   = (pos_q == PosMax);
  assign Smed   = (pos_q == PosMed);
  assign Sinf   = (pos_q == '0);
  assign fault  = (state_q == StFalla);
  assign moving = ((state_q == StSubiendo) && (pos_q != PosMax)) ||
                  ((state_q == StBajando) && (pos_q != '0));

endmodule

// File: tb/tb_persiana_planta.sv
// Self-checking bench for persiana_planta: a travel-time model of the blind plus
// directed scenarios with hand-computed positions.
module tb_persiana_planta;

  localparam int TT   = 4;
  localparam int PMAX = 12;
  localparam int PMED = 6;

  logic       Reloj;
  logic       reset;
  logic       subir;
  logic       bajar;
  logic       Ssup;
  logic       Smed;
  logic       Sinf;
  logic [3:0] pos;
  logic       moving;
  logic       fault;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  persiana_planta #(
    .TRAVEL_TICKS(TT),
    .POS_W       (4),
    .POS_MAX     (PMAX),
    .MED_POS     (PMED),
    .RESET_POS   (0)
  ) dut (
    .Reloj (Reloj),
    .reset (reset),
    .subir (subir),
    .bajar (bajar),
    .Ssup  (Ssup),
    .Smed  (Smed),
    .Sinf  (Sinf),
    .pos   (pos),
    .moving(moving),
    .fault (fault)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 up, 2 down, 3 fault. Position while running is the entry
  // position plus whole travel periods elapsed since entry, clamped to the end stops.
  int m_mode;
  int m_p0;
  int m_n;
  int m_pos;

  always @(posedge Reloj or posedge reset) begin
    if (reset) begin
      m_mode = 0;
      m_pos  = 0;
      m_p0   = 0;
      m_n    = 0;
    end else begin
      if (subir && bajar) begin
        m_mode = 3;
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (subir || bajar) begin
          m_mode = subir ? 1 : 2;
          m_p0   = m_pos;
          m_n    = 0;
        end
      end else if (m_mode == 1) begin
        if (bajar || !subir) m_mode = 0;
        else                 m_n++;
      end else begin
        if (subir || !bajar) m_mode = 0;
        else                 m_n++;
      end
      if (m_mode == 1) begin
        m_pos = m_p0 + m_n / TT;
        if (m_pos > PMAX) m_pos = PMAX;
      end else if (m_mode == 2) begin
        m_pos = m_p0 - m_n / TT;
        if (m_pos < 0) m_pos = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(posedge Reloj) begin
    #1;
    if (check_en) begin
      chk("m_pos",    int'(pos),    m_pos);
      chk("m_ssup",   int'(Ssup),   int'(m_pos == PMAX));
      chk("m_smed",   int'(Smed),   int'(m_pos == PMED));
      chk("m_sinf",   int'(Sinf),   int'(m_pos == 0));
      chk("m_fault",  int'(fault),  int'(m_mode == 3));
      chk("m_moving", int'(moving),
          int'((m_mode == 1 && m_pos != PMAX) || (m_mode == 2 && m_pos != 0)));
    end
  end

  task automatic edge1();
    @(posedge Reloj);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    subir = 1'b0;
    bajar = 1'b0;
    #12;
    chk("rst_pos",  int'(pos),  0);
    chk("rst_sinf", int'(Sinf), 1);
    chk("rst_ssup", int'(Ssup), 0);
    @(negedge Reloj);
    reset    = 1'b0;
    check_en = 1'b1;

    // Full upward travel from closed.
    subir = 1'b1;
    for (int k = 1; k <= 69; k++) begin
      edge1();
      if (k == 1)  chk("up_enter_moving", int'(moving), 1);
      if (k == 4)  chk("up_e4_pos", int'(pos), 0);
      if (k == 5)  chk("up_e5_pos", int'(pos), 1);
      if (k == 24) chk("up_e24_smed", int'(Smed), 0);
      if (k == 25) chk("up_e25_pos", int'(pos), 6);
      if (k == 25) chk("up_e25_smed", int'(Smed), 1);
      if (k == 28) chk("up_e28_smed", int'(Smed), 1);
      if (k == 29) chk("up_e29_smed", int'(Smed), 0);
      if (k == 49) chk("up_e49_pos", int'(pos), 12);
      if (k == 49) chk("up_e49_ssup", int'(Ssup), 1);
      if (k == 69) chk("up_hold_pos", int'(pos), 12);
      if (k == 69) chk("up_hold_moving", int'(moving), 0);
    end

    // Release, then a short bajar pulse that must not step.
    @(negedge Reloj);
    subir = 1'b0;
    repeat (2) @(negedge Reloj);
    bajar = 1'b1;
    repeat (3) @(negedge Reloj);
    bajar = 1'b0;
    edge1();
    chk("pulse_pos", int'(pos), 12);

    // Entry edge plus 8 edges of descent: two steps.
    @(negedge Reloj);
    bajar = 1'b1;
    repeat (9) edge1();
    chk("down8_pos", int'(pos), 10);

    // Keep descending to the bottom and well beyond it.
    repeat (90) edge1();
    chk("clamp_pos",    int'(pos),    0);
    chk("clamp_sinf",   int'(Sinf),   1);
    chk("clamp_moving", int'(moving), 0);

    // Climb to 3, then reverse on a single edge.
    @(negedge Reloj);
    bajar = 1'b0;
    @(negedge Reloj);
    subir = 1'b1;
    repeat (13) edge1();
    chk("rev_start_pos", int'(pos), 3);
    @(negedge Reloj);
    subir = 1'b0;
    bajar = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      edge1();
      if (k == 1) chk("rev_dead_moving", int'(moving), 0);
      if (k == 2) chk("rev_enter_moving", int'(moving), 1);
      if (k == 5) chk("rev_e3_pos", int'(pos), 3);
      if (k == 6) chk("rev_e4_pos", int'(pos), 2);
    end

    // Back up to 5, then both commands.
    @(negedge Reloj);
    bajar = 1'b0;
    subir = 1'b1;
    repeat (14) edge1();
    chk("flt_start_pos", int'(pos), 5);
    @(negedge Reloj);
    bajar = 1'b1;
    edge1();
    chk("flt_fault", int'(fault), 1);
    repeat (3) edge1();
    chk("flt_frozen_pos", int'(pos), 5);
    @(negedge Reloj);
    bajar = 1'b0;
    edge1();
    chk("flt_exit_fault",  int'(fault),  0);
    chk("flt_exit_moving", int'(moving), 0);
    edge1();
    chk("flt_restart_moving", int'(moving), 1);

    // Run to 7 then assert reset mid-cycle while travelling.
    repeat (10) edge1();
    chk("mid_pos", int'(pos), 7);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pos",    int'(pos),    0);
    chk("arst_sinf",   int'(Sinf),   1);
    chk("arst_moving", int'(moving), 0);
    chk("arst_fault",  int'(fault),  0);
    @(negedge Reloj);
    subir = 1'b0;
    reset = 1'b0;
    repeat (3) edge1();
    chk("post_rst_pos", int'(pos), 0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/persiana_planta.md
Name: persiana_planta

Overview:
- Plant emulator for the automatic blind: the other end of the motor/limit-switch interface.
- Consumes the motor commands `subir`/`bajar` and models blind travel with a position counter.
- Drives the three position sensors `Ssup`/`Smed`/`Sinf` back to the controller.
- Used on-chip for closed-loop demo and self-test, and as the reference plant in verification.

Parameters:
- TRAVEL_TICKS, 4: clock cycles per one position step while the motor runs (>=1).
- POS_W, 4: width of the position counter.
- POS_MAX, 12: fully-open position, where Ssup asserts (<= 2^POS_W-1).
- MED_POS, 6: half-open position, where Smed asserts (0 < MED_POS < POS_MAX).
- RESET_POS, 0: position loaded on reset; 0 = fully closed.

Ports:
- Reloj, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- subir, input, 1: motor up command from the controller.
- bajar, input, 1: motor down command from the controller.
- Ssup, output, 1: upper limit sensor; high iff pos == POS_MAX.
- Smed, output, 1: middle sensor; high iff pos == MED_POS.
- Sinf, output, 1: lower limit sensor; high iff pos == 0.
- pos, output, POS_W: current modelled blind position.
- moving, output, 1: high while the blind is actually travelling.
- fault, output, 1: high while in state FALLA (both commands asserted).

Behaviour:
- State register (2 bits): REPOSO, SUBIENDO, BAJANDO, FALLA. Tick counter `cnt` is wide enough for TRAVEL_TICKS-1.
- Reset (async, any time including mid-travel):
  - state = REPOSO, cnt = 0, pos = RESET_POS; fault = 0, moving = 0.
  - Sensors follow pos immediately: with the default, Sinf = 1, Ssup = 0, Smed = 0.
- Sensor outputs are combinational decodes of registered pos only. They change on the same edge as pos and never depend on subir/bajar.
- Transitions, evaluated every edge with priority top-down:
  - subir & bajar -> FALLA, from any state.
  - FALLA: stays while both are high. Goes to REPOSO when both are low. Goes to REPOSO when only one is high: no direct restart, one REPOSO cycle is mandatory.
  - REPOSO: subir -> SUBIENDO; bajar -> BAJANDO; else stay.
  - SUBIENDO: bajar -> REPOSO (reversal dead time of one cycle); !subir -> REPOSO; else stay.
  - BAJANDO: mirror of SUBIENDO.
- cnt and pos update rules:
  - cnt is cleared on every entry into SUBIENDO or BAJANDO, and is 0 in REPOSO and FALLA.
  - In SUBIENDO with pos < POS_MAX: if cnt == TRAVEL_TICKS-1 then pos <= pos+1 and cnt <= 0; else cnt <= cnt+1.
  - The first step therefore lands on the TRAVEL_TICKS-th edge spent in SUBIENDO.
  - In SUBIENDO with pos == POS_MAX: pos holds, cnt held at 0. pos never exceeds POS_MAX, so there is no wrap.
  - BAJANDO: same rules, decrementing. At pos == 0, pos holds and cnt is held at 0. No underflow wrap.
- Leaving a motion state discards partial cnt progress. No fractional step is retained.
- moving = (state == SUBIENDO && pos != POS_MAX) || (state == BAJANDO && pos != 0). It is combinational from registered state and pos.
- fault = (state == FALLA). pos is frozen in FALLA.
- Commands are sampled synchronously. No debounce: they come from the synchronous controller FSM.

Test Plan:
- Reset at pos=7 mid-travel in SUBIENDO -> pos = 0, Sinf = 1, moving = 0, fault = 0 asynchronously, before the next edge.
- From pos=0, hold subir (TRAVEL_TICKS=4): enter SUBIENDO at edge 1; pos = 1 at edge 5, 6 at edge 25 (Smed = 1 for edges 25..28 only), 12 at edge 49 (Ssup = 1). Then moving = 0 and pos stays 12 for 20 more cycles.
- From pos=12, pulse bajar for 3 cycles -> no step (cnt discarded), pos = 12. Then hold bajar 8 cycles in BAJANDO -> pos = 10.
- Reversal: in SUBIENDO at pos=3, set subir = 0 and bajar = 1 on the same edge -> one cycle in REPOSO, then BAJANDO; pos = 2 exactly 4 edges after entering BAJANDO.
- subir = bajar = 1 at pos=5 -> fault = 1 next edge, pos frozen. Drop bajar only -> REPOSO (fault = 0), then SUBIENDO the following edge.
- Bottom clamp: at pos=0, hold bajar 50 cycles -> pos = 0, Sinf = 1, moving = 0, no wrap to 15.
